hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline.
- Drives the PC write enable, the IF/ID write-enable and flush, and the ID/EX bubble input (null).
- Detects load-use hazards, taken branches resolved in EX, and jumps resolved in ID.
- Sequences multi-cycle mult/div occupancy with an internal busy counter, stalling HI/LO readers and back-to-back MDU ops.

Parameters:
- MUL_LAT, 4: busy cycles after a mult/multu leaves ID.
- DIV_LAT, 32: busy cycles after a div/divu leaves ID.
- CNT_W, 6: busy-counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rs_id  in  5  Rs of instruction in ID.
- rt_id  in  5  Rt of instruction in ID.
- use_rs_id  in  1  ID instruction reads Rs.
- use_rt_id  in  1  ID instruction reads Rt.
- memrd_ex  in  1  MemRd of instruction in EX (ID/EX output).
- rt_ex  in  5  load destination Rt in EX.
- branch_taken_ex  in  1  branch in EX resolved taken.
- jump_id  in  1  j/jal/jr/jalr in ID.
- mdu_op_id  in  1  mult/multu/div/divu in ID.
- mdu_div_id  in  1  1 = div type, 0 = mult type; valid with mdu_op_id.
- hilo_rd_id  in  1  mfhi/mflo/mthi/mtlo in ID.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID load NOP.
- idex_null  out  1  ID/EX bubble insert.
- mdu_busy  out  1  busy counter non-zero.
- stall_cnt  out  32  performance counter (see Optional Feature).

Behaviour:
- Outputs are combinational from inputs plus state, so they act in the same cycle.
- State consists of busy_cnt[CNT_W-1:0] and FSM {IDLE, MDU_BUSY}; mdu_busy = (state == MDU_BUSY).
- During reset: pc_we=0, ifid_we=0, ifid_flush=1, idex_null=1, mdu_busy=0, busy_cnt=0, state=IDLE, stall_cnt=0.
- load_use = memrd_ex & (rt_ex != 0) & ((use_rs_id & rs_id == rt_ex) | (use_rt_id & rt_id == rt_ex)).
- mdu_stall = mdu_busy & (hilo_rd_id | mdu_op_id).
- stall = load_use | mdu_stall.
- Priority 1, branch_taken_ex: ifid_flush=1, idex_null=1, pc_we=1, ifid_we=1. Stall is ignored because the ID instruction is squashed.
- Priority 2, stall: pc_we=0, ifid_we=0, idex_null=1, ifid_flush=0.
- Priority 3, jump_id: ifid_flush=1, pc_we=1, ifid_we=1, idex_null=0. The jump itself proceeds to EX.
- Otherwise: pc_we=1, ifid_we=1, ifid_flush=0, idex_null=0.
- Issue event = mdu_op_id & ~stall & ~branch_taken_ex.
- On an issue event the next edge loads busy_cnt = DIV_LAT when mdu_div_id is 1, else MUL_LAT, and sets state=MDU_BUSY.
- In MDU_BUSY, busy_cnt decrements each edge. The edge where busy_cnt == 1 makes busy_cnt=0 and state=IDLE.
- An issue event cannot occur in MDU_BUSY, because mdu_op_id stalls there.
- Timing: an MDU op in ID at cycle t makes an HI/LO reader in ID stall for cycles t+1 .. t+LAT and advance at t+LAT+1.
- branch_taken_ex while in MDU_BUSY does not clear the counter, since the MDU op is older and committed.
- Reset asserted mid-count returns to IDLE with busy_cnt=0 immediately.
- A register index of 0 never creates a load-use hazard.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: stall_cnt increments by 1 on every edge where stall=1 and branch_taken_ex=0. It saturates at 32'hFFFFFFFF and resets to 0.
- Undefined: stall_cnt is tied to 32'h0 and no counter flops exist.

Test Plan:
- Load-use stall: lw $8 in EX (memrd_ex=1, rt_ex=8); ID add with rs_id=8, use_rs_id=1. Required: one cycle with pc_we=0, ifid_we=0, idex_null=1; next cycle (memrd_ex=0) all enables are 1.
- Zero register: memrd_ex=1, rt_ex=0, rs_id=0, use_rs_id=1. Required: no stall; pc_we=1, idex_null=0.
- Branch over stall: load-use condition plus branch_taken_ex=1 in the same cycle. Required: ifid_flush=1, idex_null=1, pc_we=1, ifid_we=1.
- Mult then mfhi: with MUL_LAT=4, mult in ID at cycle 0, mfhi in ID from cycle 1. Required: stall in cycles 1-4, mdu_busy=1 in cycles 1-4, mfhi advances at cycle 5.
- Div with mid-count reset: with DIV_LAT=32, div issues, then reset is asserted at count 10. Required: mdu_busy drops to 0 asynchronously, and a following mfhi is not stalled.
- Jump flush: with HAZ_PERF_CNT_EN defined, jump_id=1 with no hazard. Required: ifid_flush=1, idex_null=0, stall_cnt unchanged. A separate load-use stall of 3 cycles gives stall_cnt=3.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use, branch/jump flush, MDU occupancy.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic        memrd_ex,
    input  logic [4:0]  rt_ex,
    input  logic        branch_taken_ex,
    input  logic        jump_id,
    input  logic        mdu_op_id,
    input  logic        mdu_div_id,
    input  logic        hilo_rd_id,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_null,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] busy_cnt_nxt;
    logic             load_use;
    logic             mdu_stall;
    logic             stall;
    logic             issue;

    // State register; reset clears any in-flight MDU occupancy immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy_cnt <= '0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    // Hazard detection, pipeline control priority and MDU sequencing
    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_null    = 1'b0;

        mdu_busy  = (state == MDU_BUSY);
        load_use  = memrd_ex && (rt_ex != 5'd0) &&
                    ((use_rs_id && (rs_id == rt_ex)) || (use_rt_id && (rt_id == rt_ex)));
        mdu_stall = mdu_busy && (hilo_rd_id || mdu_op_id);
        stall     = load_use || mdu_stall;
        issue     = mdu_op_id && !stall && !branch_taken_ex;

        if (reset) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_null  = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_null  = 1'b1;
        end else if (stall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_null  = 1'b1;
        end else if (jump_id) begin
            ifid_flush = 1'b1;
        end

        case (state)
            IDLE: begin
                if (issue) begin
                    busy_cnt_nxt = mdu_div_id ? DIV_LOAD : MUL_LOAD;
                    state_nxt    = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                // Older MDU op is committed, so a taken branch does not cancel it
                if (busy_cnt <= CNT_ONE) begin
                    busy_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else begin
                    busy_cnt_nxt = busy_cnt - CNT_ONE;
                end
            end
            default: begin
                busy_cnt_nxt = '0;
                state_nxt    = IDLE;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_q;

    // Saturating count of cycles lost to real (non-squashed) stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 32'h0;
        end else if (stall && !branch_taken_ex && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cnt = perf_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule
